// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, WIDTH iterations plus one fix-up cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMthi = 6'b010001;
  localparam logic [5:0] FnMflo = 6'b010010;
  localparam logic [5:0] FnMtlo = 6'b010011;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       dvd_q, dvd_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;
  logic                   dbz_q, dbz_d;

  // Launch decode and operand magnitudes
  logic                   is_muldiv;
  logic                   op_signed;
  logic                   rs_neg, rt_neg;
  logic [WIDTH-1:0]       rs_mag, rt_mag;

  assign is_muldiv = (funct[5:2] == 4'b0110);
  assign op_signed = ~funct[0];
  assign rs_neg    = op_signed & rs_val[WIDTH-1];
  assign rt_neg    = op_signed & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_val : rs_val;
  assign rt_mag    = rt_neg ? -rt_val : rt_val;

  // Multiply step: acc = {partial_hi, remaining multiplier bits}
  logic [WIDTH:0]         mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

  // Divide step: acc low half holds dividend bits shifting out and quotient bits shifting in
  logic [WIDTH:0]         div_shift;
  logic [WIDTH:0]         div_diff;
  logic                   div_ge;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, a_q};
  assign div_ge    = ~div_diff[WIDTH];

  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    dvd_d     = dvd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_muldiv) begin
            is_div_d  = funct[1];
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            dvd_d     = rs_val;
            cnt_d     = '0;
            rem_d     = '0;
            state_d   = StRun;
            if (funct[1]) begin
              a_d   = rt_mag;
              acc_d = {{WIDTH{1'b0}}, rs_mag};
            end else begin
              a_d   = rs_mag;
              acc_d = {{WIDTH{1'b0}}, rt_mag};
            end
          end else if (funct == FnMthi) begin
            hi_d = rs_val;
          end else if (funct == FnMtlo) begin
            lo_d = rs_val;
          end
        end
      end
      StRun: begin
        if (is_div_q) begin
          rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          // A zero divisor has a zero magnitude; the quotient bits are discarded
          if (a_q == '0) begin
            lo_d  = '1;
            hi_d  = dvd_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      dvd_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      dvd_q     <= dvd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  always_comb begin
    mf_data = '0;
    if (funct == FnMfhi) begin
      mf_data = hi_q;
    end else if (funct == FnMflo) begin
      mf_data = lo_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus directed literal checks.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  localparam logic [5:0] FMfhi  = 6'b010000;
  localparam logic [5:0] FMthi  = 6'b010001;
  localparam logic [5:0] FMflo  = 6'b010010;
  localparam logic [5:0] FMtlo  = 6'b010011;
  localparam logic [5:0] FMult  = 6'b011000;
  localparam logic [5:0] FMultu = 6'b011001;
  localparam logic [5:0] FDiv   = 6'b011010;
  localparam logic [5:0] FDivu  = 6'b011011;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo, mf_data;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .funct       (funct),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .mf_data     (mf_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result as {div_by_zero, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] model_op(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    q  = '0;
    r  = '0;
    case (f)
      FMult: begin
        sp = sa * sb;
        return {1'b0, 64'(sp)};
      end
      FMultu: begin
        up = ua * ub;
        return {1'b0, up};
      end
      FDiv, FDivu: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (f == FDiv) begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end else begin
          q = 32'(ua / ub);
          r = 32'(ua % ub);
        end
        return {1'b0, r, q};
      end
      default: return '0;
    endcase
  endfunction

  // Cycle-level transaction model: pending result lands WIDTH+1 edges after launch
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_done = 1'b0, m_dbz = 1'b0;
  int           m_left = 0;
  logic [64:0]  p_res = '0;

  always @(posedge clk) begin
    m_done = 1'b0;
    m_dbz  = 1'b0;
    if (reset) begin
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = p_res[63:32];
        m_lo   = p_res[31:0];
        m_dbz  = p_res[64];
        m_done = 1'b1;
      end
    end else if (start) begin
      case (funct)
        FMult, FMultu, FDiv, FDivu: begin
          p_res  = model_op(funct, rs_val, rt_val);
          m_left = W + 1;
        end
        FMthi:   m_hi = rs_val;
        FMtlo:   m_lo = rs_val;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] exp_mf;
    if (chk_en) begin
      exp_mf = (funct == FMfhi) ? m_hi : (funct == FMflo) ? m_lo : '0;
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("mf_data", 64'(mf_data), 64'(exp_mf));
    end
  end

  // Called away from a clock edge; the launch edge is the next posedge
  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct  = f;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct = 6'b0;
  endtask

  // Returns inside the done cycle, 1 time unit after its negedge
  task automatic wait_done(output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
    end
    #1;
  endtask

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[7] = '{
    '{FDiv,   32'h0000_0007, 32'hFFFF_FFFE},
    '{FDiv,   32'hFFFF_FFF9, 32'h0000_0000},
    '{FMult,  32'h8000_0000, 32'h8000_0000},
    '{FMult,  32'h0000_0000, 32'hFFFF_FFFB},
    '{FDivu,  32'hFFFF_FFFF, 32'h0000_0007},
    '{FMultu, 32'h8000_0000, 32'h0000_0003},
    '{FDiv,   32'h8000_0000, 32'h0000_0003}
  };

  int bc;
  int done_seen;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    funct  = 6'b0;
    rs_val = '0;
    rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset  = 1'b0;
    funct  = FMfhi;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_mf", 64'(mf_data), 64'd0);
    #1;
    funct = 6'b0;

    launch(FMult, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(bc);
    chk("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFF1);
    chk("mult_busy_cycles", 64'(bc), 64'd33);

    launch(FMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);
    // Launched inside the done cycle
    launch(FMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("mult_b2b_hi", 64'(hi), 64'h0);
    chk("mult_b2b_lo", 64'(lo), 64'h1);
    chk("mult_b2b_cycles", 64'(bc), 64'd33);

    launch(FDiv, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(bc);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    launch(FDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0);
    chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);

    launch(FDivu, 32'h0000_0064, 32'h0000_0000);
    wait_done(bc);
    chk("divu_dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("divu_dbz_hi", 64'(hi), 64'h0000_0064);
    chk("divu_dbz_flag", 64'(div_by_zero), 64'd1);
    chk("divu_dbz_cycles", 64'(bc), 64'd33);
    @(negedge clk);
    chk("divu_dbz_flag_drop", 64'(div_by_zero), 64'd0);
    #1;

    start  = 1'b1;
    funct  = FMthi;
    rs_val = 32'h1234_5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct = FMfhi;
    @(negedge clk);
    chk("mthi_mfhi", 64'(mf_data), 64'h1234_5678);
    #1;
    start  = 1'b1;
    funct  = FMtlo;
    rs_val = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct = FMflo;
    @(negedge clk);
    chk("mtlo_mflo", 64'(mf_data), 64'h0BAD_F00D);
    #1;

    // mtlo issued while busy must be dropped
    launch(FMult, 32'h0000_0003, 32'h0000_0005);
    start  = 1'b1;
    funct  = FMtlo;
    rs_val = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct = FMflo;
    @(negedge clk);
    chk("mtlo_busy_ignored", 64'(lo), 64'h0BAD_F00D);
    chk("mflo_while_busy", 64'(mf_data), 64'h0BAD_F00D);
    #1;
    funct = 6'b0;
    wait_done(bc);
    chk("mult_after_mtlo_lo", 64'(lo), 64'h0000_000F);
    chk("mult_after_mtlo_hi", 64'(hi), 64'h0);

    foreach (vecs[i]) begin
      launch(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(bc);
    end

    // Reset sampled at the 10th edge after launch
    launch(FDiv, 32'h0000_0064, 32'h0000_0007);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("rst_mid_no_done", 64'(done_seen), 64'd0);
    #1;

    start  = 1'b1;
    funct  = FMult;
    rs_val = 32'h0000_0009;
    rt_val = 32'h0000_0009;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    funct = 6'b0;
    @(negedge clk);
    chk("reset_beats_start", 64'(busy), 64'd0);
    #1;

    launch(FMult, 32'h0000_0007, 32'hFFFF_FFFA);
    wait_done(bc);
    chk("fresh_mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("fresh_mult_lo", 64'(lo), 64'hFFFF_FFD6);
    chk("fresh_mult_cycles", 64'(bc), 64'd33);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
